sram_burst_ctrl: RTL

- Burst master that converts a command/stream handshake interface into the pin protocol of the team's single-port SRAM.
- Pin protocol: active-low cs/we/oe, registered read data, bidirectional data bus.
- Sits between the layer datapath (weight/feature loader and result writer) and the sram instance, one controller per SRAM.
- Owns address generation, bus direction and read-data capture.

---
 rtl/sram_burst_ctrl_pkg.sv | 16 +
 rtl/sram_burst_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and pin-level constants for the SRAM burst controller.
package sram_burst_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RA    = 3'd2,
        S_RD    = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    // SRAM control pins are active-low.
    localparam logic PIN_ON  = 1'b0;
    localparam logic PIN_OFF = 1'b1;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Burst master: turns a command/stream handshake into single-port SRAM pin
// activity. Owns address generation, bus direction and read-data capture.
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 14,
    parameter int unsigned LW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [LW-1:0] cmd_len_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [DW-1:0] wr_data_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] sram_a_o,
    output logic          sram_cs_o,
    output logic          sram_we_o,
    output logic          sram_oe_o,
    inout  logic [DW-1:0] sram_d_io
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          done_q, done_d;
    logic          drive_wr;
    logic          capture;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic and SRAM pin decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        drive_wr  = 1'b0;
        capture   = 1'b0;
        sram_cs_o = PIN_OFF;
        sram_we_o = PIN_OFF;
        sram_oe_o = PIN_OFF;

        // A capture in the same cycle overrides the handshake clear below.
        rd_valid_d = rd_valid_q && !rd_ready_i;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    rem_d  = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_write_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RA;
                    end
                end
            end
            S_WR: begin
                if (wr_valid_i) begin
                    drive_wr  = 1'b1;
                    sram_cs_o = PIN_ON;
                    sram_we_o = PIN_ON;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RA: begin
                sram_cs_o = PIN_ON;
                sram_oe_o = PIN_ON;
                state_d   = S_RD;
            end
            S_RD: begin
                sram_cs_o = PIN_ON;
                sram_oe_o = PIN_ON;
                if (!rd_valid_q || rd_ready_i) begin
                    capture   = 1'b1;
                    rd_data_d = sram_d_io;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    state_d   = (rem_q > LW'(1)) ? S_RA : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_valid_q && rd_ready_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            rd_valid_d = 1'b1;
        end
    end

    assign sram_d_io   = drive_wr ? wr_data_i : 'z;
    assign sram_a_o    = addr_q;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign wr_ready_o  = (state_q == S_WR);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;

endmodule
